rv32m_mul_unit: RTL

Pipelined RV32M multiply front-end wrapped around the combinational `Mul32U` 32x32 unsigned array multiplier. It accepts one MUL/MULH/MULHSU/MULHU request per cycle from the execute stage over a valid/ready handshake. It converts signed operands to magnitudes, feeds `Mul32U`, and applies the sign fix-up to the 64-bit product. It returns the selected 32-bit half to writeback with its destination tag.

---
 rtl/rv32m_mul_unit.sv | 127 ++++++++++++
 1 files changed

// File: rtl/rv32m_mul_unit.sv
// RV32M multiply front-end: two-stage valid/ready pipeline around an unsigned
// 32x32 array multiplier, with operand magnitude conversion and product sign fix-up.

module Mul32U (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] res
);
    logic [63:0] pp [32];

    for (genvar i = 0; i < 32; i++) begin : g_pp
        assign pp[i] = b[i] ? ({32'b0, a} << i) : 64'd0;
    end

    always_comb begin
        res = 64'd0;
        for (int i = 0; i < 32; i++) begin
            res = res + pp[i];
        end
    end
endmodule

module rv32m_mul_unit #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [31:0]      in_rs1,
    input  logic [31:0]      in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_res,
    output logic [TAG_W-1:0] out_tag
);
    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    logic             s1_valid_q;
    logic [31:0]      s1_mag1_q, s1_mag1_d;
    logic [31:0]      s1_mag2_q, s1_mag2_d;
    logic             s1_neg_q, s1_neg_d;
    logic             s1_hi_q, s1_hi_d;
    logic [TAG_W-1:0] s1_tag_q;

    logic             out_valid_q;
    logic [31:0]      out_res_q, out_res_d;
    logic [TAG_W-1:0] out_tag_q;

    logic             s2_free, s1_adv, accept;
    logic             neg1, neg2;
    logic [63:0]      prod, prod_fix;

    assign s2_free  = !out_valid_q || out_ready;
    assign s1_adv   = s1_valid_q && s2_free;
    assign in_ready = !s1_valid_q || s2_free;
    // A request offered during a flush is dropped even though in_ready may be high.
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        neg1      = ((in_op == OP_MULH) || (in_op == OP_MULHSU)) && in_rs1[31];
        neg2      = (in_op == OP_MULH) && in_rs2[31];
        s1_mag1_d = neg1 ? (~in_rs1 + 32'd1) : in_rs1;
        s1_mag2_d = neg2 ? (~in_rs2 + 32'd1) : in_rs2;
        s1_neg_d  = neg1 ^ neg2;
        s1_hi_d   = (in_op != OP_MUL);
    end

    Mul32U u_mul (
        .a   (s1_mag1_q),
        .b   (s1_mag2_q),
        .res (prod)
    );

    // Negating a zero product stays zero, so 0 * negative never yields all-ones.
    always_comb begin
        prod_fix  = s1_neg_q ? (~prod + 64'd1) : prod;
        out_res_d = s1_hi_q ? prod_fix[63:32] : prod_fix[31:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_mag1_q  <= 32'd0;
            s1_mag2_q  <= 32'd0;
            s1_neg_q   <= 1'b0;
            s1_hi_q    <= 1'b0;
            s1_tag_q   <= '0;
        end else if (flush) begin
            s1_valid_q <= 1'b0;
        end else if (accept) begin
            s1_valid_q <= 1'b1;
            s1_mag1_q  <= s1_mag1_d;
            s1_mag2_q  <= s1_mag2_d;
            s1_neg_q   <= s1_neg_d;
            s1_hi_q    <= s1_hi_d;
            s1_tag_q   <= in_tag;
        end else if (s1_adv) begin
            s1_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_res_q   <= 32'd0;
            out_tag_q   <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (s1_adv) begin
            out_valid_q <= 1'b1;
            out_res_q   <= out_res_d;
            out_tag_q   <= s1_tag_q;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_res   = out_res_q;
    assign out_tag   = out_tag_q;
endmodule
